tmds_decoder_dvi: RTL

//  Receive-side counterpart of the DVI TMDS encoder. Takes one 10-bit TMDS symbol per pixel clock from a

---
 rtl/tmds_decoder_dvi.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/tmds_decoder_dvi.sv
// tmds_decoder_dvi: one DVI TMDS channel decoder with a control-token lock FSM.
// Optional macro TMDS_ERR_CNT_EN builds the saturating lock-loss counter.
module tmds_decoder_dvi #(
    parameter int CTRL_RUN    = 64,
    parameter int SLIP_WAIT   = 4096,
    parameter int LOSS_WINDOW = 2048,
    parameter int ERR_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [9:0]       i_tmds,
    output logic [7:0]       o_data,
    output logic [1:0]       o_ctrl,
    output logic             o_de,
    output logic             o_locked,
    output logic             o_bitslip,
    output logic [ERR_W-1:0] o_err_count
);
    localparam int RUN_W = $clog2(CTRL_RUN) + 1;
    localparam int TMR_W = $clog2(SLIP_WAIT) + 1;
    localparam int WD_W  = $clog2(LOSS_WINDOW) + 1;

    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(CTRL_RUN - 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(CTRL_RUN);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SLIP_WAIT - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(LOSS_WINDOW - 1);

    typedef enum logic {
        HUNT,
        LOCKED
    } state_t;

    logic             tok_hit;
    logic [1:0]       tok_val;
    logic [9:0]       s1_q;
    logic             s1_ctl;
    logic [1:0]       s1_val;
    logic [7:0]       d;
    logic [7:0]       dec;
    state_t           state;
    state_t           state_d;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_d;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_d;
    logic [WD_W-1:0]  wdog;
    logic [WD_W-1:0]  wdog_d;
    logic             run_hit;
    logic             slip;
    logic             locked_d;

    // Classify the incoming symbol as one of the four control tokens or data
    always_comb begin
        tok_hit = 1'b1;
        tok_val = 2'b00;
        unique case (i_tmds)
            10'b1101010100: tok_val = 2'b00;
            10'b0010101011: tok_val = 2'b01;
            10'b0101010100: tok_val = 2'b10;
            10'b1010101011: tok_val = 2'b11;
            default:        tok_hit = 1'b0;
        endcase
    end

    // Stage 1: register the raw symbol and its classification
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_q   <= '0;
            s1_ctl <= 1'b0;
            s1_val <= 2'b00;
        end else begin
            s1_q   <= i_tmds;
            s1_ctl <= tok_hit;
            s1_val <= tok_val;
        end
    end

    // Undo the optional inversion, then the XOR/XNOR transition chain
    always_comb begin
        d      = s1_q[9] ? ~s1_q[7:0] : s1_q[7:0];
        dec    = '0;
        dec[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            dec[i] = s1_q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
    end

    assign run_hit = s1_ctl && (run == RUN_LAST);

    // Lock FSM next state: token-run counting, slip timer, loss watchdog
    always_comb begin
        state_d = state;
        run_d   = run;
        timer_d = timer;
        wdog_d  = wdog;
        slip    = 1'b0;
        if (!s1_ctl) begin
            run_d = '0;
        end else if (run != RUN_MAX) begin
            run_d = run + 1'b1;
        end
        unique case (state)
            HUNT: begin
                timer_d = timer + 1'b1;
                if (run_hit) begin
                    state_d = LOCKED;
                    timer_d = '0;
                    wdog_d  = '0;
                end else if (timer == TMR_LAST) begin
                    slip    = 1'b1;
                    timer_d = '0;
                    run_d   = '0;
                end
            end
            LOCKED: begin
                wdog_d = wdog + 1'b1;
                if (run_hit) begin
                    wdog_d = '0;
                end else if (wdog == WD_LAST) begin
                    state_d = HUNT;
                    timer_d = '0;
                    run_d   = '0;
                    wdog_d  = '0;
                end
            end
        endcase
    end

    assign locked_d  = (state_d == LOCKED);
    assign o_bitslip = slip;

    // Lock FSM state and counters
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= HUNT;
            run   <= '0;
            timer <= '0;
            wdog  <= '0;
        end else begin
            state <= state_d;
            run   <= run_d;
            timer <= timer_d;
            wdog  <= wdog_d;
        end
    end

    // Stage 2: outputs, gated by the lock state taking effect this edge
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_data   <= '0;
            o_ctrl   <= 2'b00;
            o_de     <= 1'b0;
            o_locked <= 1'b0;
        end else begin
            o_locked <= locked_d;
            o_de     <= !s1_ctl && locked_d;
            o_data   <= (!s1_ctl && locked_d) ? dec : 8'h00;
            if (s1_ctl) begin
                o_ctrl <= s1_val;
            end
        end
    end

`ifdef TMDS_ERR_CNT_EN
    logic [ERR_W-1:0] err_cnt;

    // Count every drop out of lock, saturating at all-ones
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_cnt <= '0;
        end else if (state == LOCKED && state_d == HUNT && err_cnt != '1) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    assign o_err_count = err_cnt;
`else
    assign o_err_count = '0;
`endif

endmodule
